// File: rtl/hiscore_upload.sv
// hiscore_upload: serves HPS ioctl upload reads from a window of core work RAM.
// It holds the HPS off with ioctl_wait while it arbitrates for a shared RAM port.
// Optional feature: define HISCORE_CHECKSUM_EN to build an 8-bit running sum of the
// delivered bytes. A read of address SIZE then returns that sum.
module hiscore_upload #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned BASE   = 0,
    parameter int unsigned SIZE   = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_cpu,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout
);

    localparam logic [24:0]       SizeAddr = 25'(SIZE);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
    localparam logic [2:0]        LatInit  = 3'(RD_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StLat
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [2:0]        lat_q, lat_d;
    logic [7:0]        din_q, din_d;
    logic              pause_q;
    logic              deliver;

    // The last latency cycle delivers a RAM byte, unless the session was just closed.
    assign deliver = (state_q == StLat) && (lat_q == 3'd1) && ioctl_upload;

`ifdef HISCORE_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running sum of delivered bytes; cleared when an upload session opens.
    always_comb begin
        sum_d = sum_q;
        if (ioctl_upload && !pause_q) begin
            sum_d = 8'h00;
        end else if (deliver) begin
            sum_d = sum_q + ram_dout;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Next-state logic for the read FSM, address capture, latency count and data return.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        lat_d      = lat_q;
        din_d      = din_q;
        unique case (state_q)
            StIdle: begin
                if (ioctl_rd && ioctl_upload) begin
                    if (ioctl_addr < SizeAddr) begin
                        state_d    = StReq;
                        // Truncation to ADDR_W makes the window wrap around the RAM.
                        ram_addr_d = BaseAddr + ioctl_addr[ADDR_W-1:0];
                    end else begin
`ifdef HISCORE_CHECKSUM_EN
                        din_d = (ioctl_addr == SizeAddr) ? sum_q : 8'hFF;
`else
                        din_d = 8'hFF;
`endif
                    end
                end
            end
            StReq: begin
                if (ram_gnt) begin
                    state_d = StLat;
                    lat_d   = LatInit;
                end
            end
            StLat: begin
                if (lat_q == 3'd1) begin
                    state_d = StIdle;
                    din_d   = ram_dout;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Closing the session abandons any access in flight; the last byte stays visible.
        if (!ioctl_upload) begin
            state_d = StIdle;
            din_d   = din_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ram_addr_q <= '0;
            lat_q      <= 3'd0;
            din_q      <= 8'hFF;
            pause_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            lat_q      <= lat_d;
            din_q      <= din_d;
            pause_q    <= ioctl_upload;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = (state_q != StIdle);
    assign ram_req    = (state_q == StReq);
    assign ram_addr   = ram_addr_q;
    assign pause_cpu  = pause_q;

endmodule

// File: tb/tb_hiscore_upload.sv
// Scoreboard bench for hiscore_upload: reads push expected byte/latency, a monitor checks.
module tb_hiscore_upload;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned BASE   = 'h7FE;
    localparam int unsigned SIZE   = 4;
    localparam int unsigned RD_LAT = 2;
    localparam int          LatIn  = 2 + RD_LAT;
`ifdef HISCORE_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              pause_cpu;
    logic              ram_req;
    logic              ram_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;

    typedef struct {
        logic [7:0] din;
        int         lat;
    } exp_t;
    exp_t q[$];

    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_din;
    logic [7:0] mem [2048];

    hiscore_upload #(
        .ADDR_W(ADDR_W),
        .BASE  (BASE),
        .SIZE  (SIZE),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .pause_cpu   (pause_cpu),
        .ram_req     (ram_req),
        .ram_gnt     (ram_gnt),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model: data for a granted address is on ram_dout exactly RD_LAT (=2) cycles later.
    logic [ADDR_W-1:0] p0 = '0, p1 = '0;
    logic              v0 = 1'b0, v1 = 1'b0;
    always @(posedge clk_sys) begin
        v0 <= ram_req && ram_gnt;
        p0 <= ram_addr;
        v1 <= v0;
        p1 <= p0;
    end
    assign ram_dout = v1 ? mem[p1] : 8'h5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    // Issue one read and return in the cycle ioctl_wait is low again.
    task automatic do_read(input logic [24:0] a, input logic [7:0] d, input int lat);
        exp_t e;
        int   n;
        e.din = d;
        e.lat = lat;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        q.push_back(e);
        cyc();
        ioctl_rd = 1'b0;
        chk("wait_cycle1", {31'd0, ioctl_wait}, {31'd0, (a < SIZE)});
        if (a < SIZE) chk("ram_addr_cycle1", {21'd0, ram_addr}, {21'd0, 11'(BASE + a)});
        n = 0;
        while (ioctl_wait && n < 100) begin
            cyc();
            n++;
        end
        last_din = d;
    endtask

    // Monitor: times each accepted read until ioctl_wait is low, then checks it against the queue.
    initial begin
        bit   armed;
        int   cnt;
        exp_t e;
        armed = 1'b0;
        cnt   = 0;
        forever begin
            @(negedge clk_sys);
            if (armed) begin
                cnt++;
                if (!ioctl_wait || cnt > 64) begin
                    armed = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resp_din", {24'd0, ioctl_din}, {24'd0, e.din});
                        chk("resp_latency", cnt, e.lat);
                    end
                end
            end
            if (reset_n && ioctl_rd && ioctl_upload && !ioctl_wait) begin
                armed = 1'b1;
                cnt   = 0;
            end
        end
    end

    initial begin
        int reqcnt;
        for (int i = 0; i < 2048; i++) mem[i] = 8'hEE;
        mem[11'h7FE] = 8'h10;
        mem[11'h7FF] = 8'h20;
        mem[11'h000] = 8'h30;
        mem[11'h001] = 8'hF5;

        reset_n      = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ram_gnt      = 1'b1;
        repeat (3) cyc();
        chk("rst_din", {24'd0, ioctl_din}, 32'hFF);
        chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rst_pause", {31'd0, pause_cpu}, 32'd0);
        chk("rst_req", {31'd0, ram_req}, 32'd0);
        chk("rst_addr", {21'd0, ram_addr}, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'h5A);
        reset_n = 1'b1;
        chk("pause_at_release", {31'd0, pause_cpu}, 32'd0);
        cyc();
        chk("pause_after_release", {31'd0, pause_cpu}, 32'd1);
        last_din = 8'hFF;

        // Immediate grant: ram_req for exactly one cycle.
        ioctl_addr = 25'd0;
        ioctl_rd   = 1'b1;
        q.push_back('{8'h10, LatIn});
        cyc();
        ioctl_rd = 1'b0;
        chk("c1_req", {31'd0, ram_req}, 32'd1);
        chk("c1_wait", {31'd0, ioctl_wait}, 32'd1);
        chk("c1_addr", {21'd0, ram_addr}, 32'h7FE);
        cyc();
        chk("c2_req", {31'd0, ram_req}, 32'd0);
        repeat (2) cyc();
        chk("c4_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("c4_din", {24'd0, ioctl_din}, 32'h10);

        // Grant withheld 5 cycles: ram_req high 6 cycles, wait falls at cycle 9.
        ram_gnt    = 1'b0;
        ioctl_addr = 25'd1;
        ioctl_rd   = 1'b1;
        q.push_back('{8'h20, LatIn + 5});
        cyc();
        ioctl_rd = 1'b0;
        reqcnt   = 0;
        for (int i = 0; i < 5; i++) begin
            if (ram_req) reqcnt++;
            cyc();
        end
        if (ram_req) reqcnt++;
        ram_gnt = 1'b1;
        cyc();
        chk("req_after_grant", {31'd0, ram_req}, 32'd0);
        chk("req_cycles", reqcnt, 6);
        repeat (2) cyc();
        chk("stall_wait_low", {31'd0, ioctl_wait}, 32'd0);

        // Remaining bytes, including the wrapped address 3 -> 0x001; then out-of-range reads.
        do_read(25'd2, 8'h30, LatIn);
        do_read(25'd3, 8'hF5, LatIn);
        do_read(25'd4, ChkEn ? 8'h55 : 8'hFF, 1);
        do_read(25'd5, 8'hFF, 1);
        // Back-to-back reads, each issued in the cycle wait falls.
        do_read(25'd0, 8'h10, LatIn);
        do_read(25'd2, 8'h30, LatIn);
        do_read(25'd4, ChkEn ? 8'h95 : 8'hFF, 1);

        // Session closed in LAT: idle next cycle, datum arriving later is discarded.
        ioctl_addr = 25'd1;
        ioctl_rd   = 1'b1;
        q.push_back('{last_din, 3});
        cyc();
        ioctl_rd = 1'b0;
        cyc();
        ioctl_upload = 1'b0;
        cyc();
        chk("abort_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("abort_req", {31'd0, ram_req}, 32'd0);
        chk("abort_din", {24'd0, ioctl_din}, {24'd0, last_din});
        chk("abort_pause", {31'd0, pause_cpu}, 32'd0);
        repeat (2) cyc();
        chk("abort_din_later", {24'd0, ioctl_din}, {24'd0, last_din});

        // Read strobe without an upload session is ignored.
        ioctl_addr = 25'd0;
        ioctl_rd   = 1'b1;
        cyc();
        ioctl_rd = 1'b0;
        chk("noupl_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("noupl_req", {31'd0, ram_req}, 32'd0);
        cyc();
        chk("noupl_din", {24'd0, ioctl_din}, {24'd0, last_din});

        // New session clears the checksum.
        ioctl_upload = 1'b1;
        cyc();
        do_read(25'd4, ChkEn ? 8'h00 : 8'hFF, 1);
        do_read(25'd3, 8'hF5, LatIn);
        do_read(25'd4, ChkEn ? 8'hF5 : 8'hFF, 1);
        do_read(25'd100, 8'hFF, 1);

        repeat (4) cyc();
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
